pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Parametrised fetch program counter for the pipelined core; next generation of the stall-only PC register.
//   Holds the fetch PC and drives a valid/ready request to instruction memory.
//   Selects next PC by priority: trap > branch > sequential; captures redirects that arrive mid-handshake.
//   Inserts a one-cycle boot bubble after reset release, and flags misaligned redirect targets.
// PARAMETERS
//   XLEN          64   PC / address width in bits
//   RESET_VECTOR  0    pc_out value during and after reset (XLEN bits, INST_BYTES-aligned)
//   INST_BYTES    4    sequential increment; power of two >= 2; ALIGN = $clog2(INST_BYTES)
// PORTS
//   clk              in   1     clock, all state on rising edge
//   reset            in   1     reset, asynchronous, active-low
//   pc_write         in   1     1 = may start a new fetch; 0 = stall (hazard unit)
//   branch_taken     in   1     branch/jump redirect request, 1-cycle pulse
//   branch_target    in   XLEN  branch redirect address
//   trap_req         in   1     trap/exception redirect request, 1-cycle pulse
//   trap_vector      in   XLEN  trap handler address
//   fetch_ready      in   1     imem accepts request this cycle
//   fetch_valid      out  1     fetch request valid, address = pc_out
//   pc_out           out  XLEN  current fetch PC (registered)
//   pc_plus_inc      out  XLEN  pc_out + INST_BYTES, combinational, mod 2^XLEN
//   redirect_pending out  1     a captured redirect awaits the handshake
//   misalign_err     out  1     1-cycle pulse: applied redirect target had nonzero low ALIGN bits
// BEHAVIOUR
//   Reset (reset=0, any time, mid-handshake included): state=BOOT, pc_out=RESET_VECTOR, fetch_valid=0,
//     redirect_pending=0, misalign_err=0, pending target cleared. Takes effect immediately, no clock needed.
//   States (registered; fetch_valid = state==ISSUE):
//     BOOT : first clk after reset release; no fetch. -> ISSUE if pc_write, else STALL.
//     ISSUE: request held with pc_out stable until fetch_ready=1. pc_write is ignored while waiting;
//            valid never drops before acceptance.
//            On fetch_ready=1: pc_out <= next, then -> ISSUE if pc_write else STALL.
//            On fetch_ready=0 with trap_req or branch_taken: capture into pending reg, pc_out holds.
//     STALL: fetch_valid=0. A redirect (or pending) loads pc_out immediately. -> ISSUE when pc_write=1.
//   next priority: pending trap > live trap_req > pending branch > live branch_taken > pc_plus_inc.
//   Pending capture rules:
//     - Trap overwrites a pending branch; a branch never overwrites a pending trap.
//     - Second branch before acceptance overwrites the first.
//     - Pending is cleared when applied.
//   Redirects in BOOT are applied to pc_out (trap > branch) and are not pending.
//   Alignment: an applied target has low ALIGN bits forced to 0; misalign_err=1 the cycle after application.
//   Sequential wrap: pc_out + INST_BYTES wraps modulo 2^XLEN (0xFFFF_FFFF_FFFF_FFFC -> 0 for defaults).
//   Latency: accepted fetch at PC p in cycle n -> pc_out = next in cycle n+1; back-to-back accept possible.
//   Simultaneous trap_req and branch_taken: trap wins; branch is dropped, not queued.
// STRUCTURE
//   pc_pkg (shared):
//     - typedef pc_state_e {BOOT, ISSUE, STALL}
//     - typedef redirect_cause_e {RD_NONE, RD_BRANCH, RD_TRAP}
//     - localparam function for ALIGN
//   Sub-module pc_redirect_arb (combinational):
//     - inputs: pending + live requests
//     - outputs: selected target, cause, misalign flag
//   pc_sequencer keeps the FSM, pc_out and pending registers.
// TESTING
//   1. Reset release, pc_write=1, fetch_ready=1 -> BOOT bubble, then fetch_valid=1 at 0x0; accepts 0x0,0x4,0x8 back-to-back.
//   2. fetch_ready=0 for 3 cycles, branch_taken pulse to 0x100 -> pc_out/valid stable, redirect_pending=1;
//      after accept pc_out=0x100, pending=0.
//   3. Branch to 0x200 pending, then trap_req to 0x80 before accept -> pc_out=0x80 next.
//      Reverse order: still 0x80.
//   4. trap_req and branch_taken same cycle with fetch_ready=1 -> pc_out=trap_vector; branch dropped.
//   5. Branch target 0x102 -> pc_out=0x100, misalign_err pulses once.
//      With pc_out=0xFFFF_FFFF_FFFF_FFFC, accept -> pc_out=0.
//   6. reset=0 mid-handshake with pending redirect -> pc_out=RESET_VECTOR, valid=0, pending=0 asynchronously;
//      the redirect is never applied.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch program counter and its redirect arbiter.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_TRAP   = 2'd2
    } redirect_cause_e;

    // Number of always-zero low PC bits for a given instruction size.
    function automatic int align_bits(input int inst_bytes);
        return $clog2(inst_bytes);
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Picks the redirect to apply this cycle: pending trap > live trap > pending branch > live branch.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int ALIGN = 2
) (
    input  redirect_cause_e   pend_cause,
    input  logic [XLEN-1:0]   pend_target,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_vector,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_target,
    output logic [XLEN-1:0]   sel_target,
    output redirect_cause_e   sel_cause,
    output logic              sel_misalign
);

    logic [XLEN-1:0] raw_target_s;

    // Priority select of the raw (unaligned) redirect target and its cause.
    always_comb begin
        raw_target_s = '0;
        sel_cause    = RD_NONE;
        if (pend_cause == RD_TRAP) begin
            raw_target_s = pend_target;
            sel_cause    = RD_TRAP;
        end else if (trap_req) begin
            raw_target_s = trap_vector;
            sel_cause    = RD_TRAP;
        end else if (pend_cause == RD_BRANCH) begin
            raw_target_s = pend_target;
            sel_cause    = RD_BRANCH;
        end else if (branch_taken) begin
            raw_target_s = branch_target;
            sel_cause    = RD_BRANCH;
        end else begin
            raw_target_s = '0;
            sel_cause    = RD_NONE;
        end
    end

    assign sel_target   = {raw_target_s[XLEN-1:ALIGN], {ALIGN{1'b0}}};
    assign sel_misalign = (sel_cause != RD_NONE) && (raw_target_s[ALIGN-1:0] != '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with valid/ready imem request, trap/branch redirect capture and boot bubble.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INST_BYTES   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            redirect_pending,
    output logic            misalign_err
);

    localparam int ALIGN = align_bits(INST_BYTES);

    pc_state_e        state_r;
    logic [XLEN-1:0]  pc_r;
    redirect_cause_e  pend_cause_r;
    logic [XLEN-1:0]  pend_target_r;
    logic             misalign_r;

    logic [XLEN-1:0]  sel_target_s;
    redirect_cause_e  sel_cause_s;
    logic             sel_misalign_s;
    logic             redirect_s;

    pc_redirect_arb #(
        .XLEN  (XLEN),
        .ALIGN (ALIGN)
    ) u_arb (
        .pend_cause    (pend_cause_r),
        .pend_target   (pend_target_r),
        .trap_req      (trap_req),
        .trap_vector   (trap_vector),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .sel_target    (sel_target_s),
        .sel_cause     (sel_cause_s),
        .sel_misalign  (sel_misalign_s)
    );

    assign redirect_s       = (sel_cause_s != RD_NONE);
    assign pc_out           = pc_r;
    assign pc_plus_inc      = pc_r + XLEN'(INST_BYTES);
    assign fetch_valid      = (state_r == ISSUE);
    assign redirect_pending = (pend_cause_r != RD_NONE);
    assign misalign_err     = misalign_r;

    // Fetch FSM, PC register and pending-redirect capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= BOOT;
            pc_r          <= RESET_VECTOR;
            pend_cause_r  <= RD_NONE;
            pend_target_r <= '0;
            misalign_r    <= 1'b0;
        end else begin
            misalign_r <= 1'b0;
            case (state_r)
                BOOT: begin
                    if (redirect_s) begin
                        pc_r       <= sel_target_s;
                        misalign_r <= sel_misalign_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    state_r <= pc_write ? ISSUE : STALL;
                end
                ISSUE: begin
                    if (fetch_ready) begin
                        if (redirect_s) begin
                            pc_r       <= sel_target_s;
                            misalign_r <= sel_misalign_s;
                        end else begin
                            pc_r <= pc_plus_inc;
                        end
                        pend_cause_r <= RD_NONE;
                        state_r      <= pc_write ? ISSUE : STALL;
                    end else if (trap_req) begin
                        // A trap always replaces whatever was waiting.
                        pend_cause_r  <= RD_TRAP;
                        pend_target_r <= trap_vector;
                    end else if (branch_taken && (pend_cause_r != RD_TRAP)) begin
                        pend_cause_r  <= RD_BRANCH;
                        pend_target_r <= branch_target;
                    end else begin
                        pend_cause_r <= pend_cause_r;
                    end
                end
                STALL: begin
                    if (redirect_s) begin
                        pc_r         <= sel_target_s;
                        misalign_r   <= sel_misalign_s;
                        pend_cause_r <= RD_NONE;
                    end else begin
                        pc_r <= pc_r;
                    end
                    state_r <= pc_write ? ISSUE : STALL;
                end
                default: begin
                    state_r      <= BOOT;
                    pend_cause_r <= RD_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot bubble, handshake stalls, redirect priority, alignment, wrap, async reset.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        trap_req;
    logic [63:0] trap_vector;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [63:0] pc_out;
    logic [63:0] pc_plus_inc;
    logic        redirect_pending;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .XLEN         (64),
        .RESET_VECTOR (64'h0),
        .INST_BYTES   (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_write         (pc_write),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .trap_req         (trap_req),
        .trap_vector      (trap_vector),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .pc_out           (pc_out),
        .pc_plus_inc      (pc_plus_inc),
        .redirect_pending (redirect_pending),
        .misalign_err     (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [63:0] pc, input logic v,
                                input logic pend, input logic mis);
        check({tag, " pc"}, pc_out, pc);
        check({tag, " valid"}, {63'd0, fetch_valid}, {63'd0, v});
        check({tag, " pending"}, {63'd0, redirect_pending}, {63'd0, pend});
        check({tag, " misalign"}, {63'd0, misalign_err}, {63'd0, mis});
    endtask

    initial begin
        reset = 1'b0; pc_write = 1'b0; fetch_ready = 1'b0;
        branch_taken = 1'b0; branch_target = 64'h0;
        trap_req = 1'b0; trap_vector = 64'h0;
        tick(); tick();
        expect_state("reset", 64'h0, 1'b0, 1'b0, 1'b0);
        check("reset pc_plus_inc", pc_plus_inc, 64'h4);

        // 1: boot bubble then back-to-back accepts
        pc_write = 1'b1; fetch_ready = 1'b1;
        reset = 1'b1;
        #1 expect_state("boot bubble", 64'h0, 1'b0, 1'b0, 1'b0);
        tick(); expect_state("first issue", 64'h0, 1'b1, 1'b0, 1'b0);
        tick(); check("seq 4", pc_out, 64'h4);
        tick(); check("seq 8", pc_out, 64'h8);
        tick(); check("seq c", pc_out, 64'hC);

        // 2: held request with a branch captured mid-handshake
        fetch_ready = 1'b0;
        branch_taken = 1'b1; branch_target = 64'h100;
        tick(); expect_state("branch captured", 64'hC, 1'b1, 1'b1, 1'b0);
        branch_taken = 1'b0;
        pc_write = 1'b0;
        tick(); expect_state("hold 2", 64'hC, 1'b1, 1'b1, 1'b0);
        pc_write = 1'b1;
        tick(); expect_state("hold 3", 64'hC, 1'b1, 1'b1, 1'b0);
        fetch_ready = 1'b1;
        tick(); expect_state("branch applied", 64'h100, 1'b1, 1'b0, 1'b0);

        // 3: trap overwrites pending branch
        fetch_ready = 1'b0;
        branch_taken = 1'b1; branch_target = 64'h200;
        tick(); branch_taken = 1'b0;
        trap_req = 1'b1; trap_vector = 64'h80;
        tick(); trap_req = 1'b0;
        check("trap over branch pend", {63'd0, redirect_pending}, 64'h1);
        fetch_ready = 1'b1;
        tick(); expect_state("trap over branch", 64'h80, 1'b1, 1'b0, 1'b0);
        // reverse: branch does not overwrite pending trap
        fetch_ready = 1'b0;
        trap_req = 1'b1; trap_vector = 64'h80;
        tick(); trap_req = 1'b0;
        branch_taken = 1'b1; branch_target = 64'h200;
        tick(); branch_taken = 1'b0;
        fetch_ready = 1'b1;
        tick(); expect_state("branch under trap", 64'h80, 1'b1, 1'b0, 1'b0);

        // 4: simultaneous live trap and branch
        trap_req = 1'b1; trap_vector = 64'h300;
        branch_taken = 1'b1; branch_target = 64'h400;
        tick(); trap_req = 1'b0; branch_taken = 1'b0;
        expect_state("simul trap", 64'h300, 1'b1, 1'b0, 1'b0);
        tick(); check("branch dropped", pc_out, 64'h304);

        // 5: misaligned target, then sequential wrap
        branch_taken = 1'b1; branch_target = 64'h102;
        tick(); branch_taken = 1'b0;
        expect_state("misalign apply", 64'h100, 1'b1, 1'b0, 1'b1);
        tick(); expect_state("misalign one pulse", 64'h104, 1'b1, 1'b0, 1'b0);
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); branch_taken = 1'b0;
        check("wrap top", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap plus_inc", pc_plus_inc, 64'h0);
        tick(); check("wrap zero", pc_out, 64'h0);

        // STALL: no request, redirect loads immediately, resume on pc_write
        pc_write = 1'b0;
        tick(); expect_state("to stall", 64'h4, 1'b0, 1'b0, 1'b0);
        branch_taken = 1'b1; branch_target = 64'h500;
        tick(); branch_taken = 1'b0;
        expect_state("stall redirect", 64'h500, 1'b0, 1'b0, 1'b0);
        pc_write = 1'b1;
        tick(); expect_state("stall resume", 64'h500, 1'b1, 1'b0, 1'b0);

        // 6: async reset mid-handshake with a pending redirect
        fetch_ready = 1'b0;
        branch_taken = 1'b1; branch_target = 64'h600;
        tick(); branch_taken = 1'b0;
        check("pre-reset pending", {63'd0, redirect_pending}, 64'h1);
        #2 reset = 1'b0;
        #1 expect_state("async reset", 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        fetch_ready = 1'b1;
        reset = 1'b1;
        tick(); expect_state("post-reset issue", 64'h0, 1'b1, 1'b0, 1'b0);
        tick(); check("redirect discarded", pc_out, 64'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
